// File: rtl/ahb_lite_master_queued_rw_pkg.sv
// Shared AHB-Lite encodings and the local-reject helper for the queued master.
package ahb_lite_master_queued_rw_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_NONSEQ = 2'b10
   } htrans_e;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic       HRESP_OKAY    = 1'b0;
   localparam logic       HRESP_ERROR   = 1'b1;

   // A command is refused locally when its size exceeds the bus width or its
   // address is not naturally aligned to that size.
   function automatic logic local_reject(input logic [7:0] addr_lo,
                                         input logic [2:0] size,
                                         input logic [2:0] max_size);
      logic [7:0] mask;
      mask = (8'd1 << size) - 8'd1;
      return (size > max_size) || ((addr_lo & mask) != 8'd0);
   endfunction

endpackage

// File: rtl/ahb_lite_master_queued_rw_fifo.sv
// Synchronous command FIFO. Pushes while full and pops while empty are ignored.
module ahb_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (PTR_W+1)'(1);
         2'b01:   count_d = count_q - (PTR_W+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer/count registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ahb_lite_master_queued_rw.sv
// Queued AHB-Lite master: command FIFO feeding an address stage (A) and a
// data stage (D). Single NONSEQ transfers, wait states, two-cycle ERROR with
// re-issue of the cancelled address phase, one in-order response per command.
module ahb_lite_master_queued_rw
   import ahb_lite_master_queued_rw_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              HCLK,
   input  logic              HRESETn,
   input  logic              HREADY,
   input  logic              HRESP,
   input  logic [DATA_W-1:0] HRDATA,
   output logic [ADDR_W-1:0] HADDR,
   output logic              HWRITE,
   output logic [2:0]        HSIZE,
   output logic [1:0]        HTRANS,
   output logic [2:0]        HBURST,
   output logic [DATA_W-1:0] HWDATA,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [2:0]        cmd_size,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic              rsp_write,
   output logic              rsp_error,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy
);
   localparam int MAX_SIZE = $clog2(DATA_W / 8);
   localparam int CMD_W    = ADDR_W + 1 + 3 + DATA_W;

   // FIFO interface
   logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [CMD_W-1:0]  fifo_rdata;
   logic [ADDR_W-1:0] head_addr;
   logic              head_write;
   logic [2:0]        head_size;
   logic [DATA_W-1:0] head_wdata;
   logic              head_rej;

   // Address stage
   logic              a_valid_q, a_valid_d;
   logic              a_rej_q, a_rej_d;
   logic [ADDR_W-1:0] a_addr_q, a_addr_d;
   logic              a_write_q, a_write_d;
   logic [2:0]        a_size_q, a_size_d;
   logic [DATA_W-1:0] a_wdata_q, a_wdata_d;

   // Data stage
   logic              d_valid_q, d_valid_d;
   logic              d_write_q, d_write_d;
   logic [DATA_W-1:0] d_wdata_q, d_wdata_d;

   // Cancel flag for the second cycle of an ERROR response
   logic              cancel_q, cancel_d;

   // Response register
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_write_q, rsp_write_d;
   logic              rsp_error_q, rsp_error_d;
   logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

   // Pipeline control
   logic a_xfer, a_to_d, rej_retire, a_free, d_done;
   htrans_e htrans;

   assign fifo_push = cmd_valid & ~fifo_full;
   assign cmd_ready = ~fifo_full;

   ahb_cmd_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (HCLK),
      .rst_n (HRESETn),
      .push  (fifo_push),
      .wdata ({cmd_addr, cmd_write, cmd_size, cmd_wdata}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign head_addr  = fifo_rdata[CMD_W-1 -: ADDR_W];
   assign head_write = fifo_rdata[DATA_W+3];
   assign head_size  = fifo_rdata[DATA_W+2 -: 3];
   assign head_wdata = fifo_rdata[DATA_W-1:0];
   assign head_rej   = local_reject(head_addr[7:0], head_size, 3'(MAX_SIZE));

   // Stage handoff: a rejected entry parks in A without a bus transfer and
   // retires only once D has drained, which keeps responses in order.
   always_comb begin
      a_xfer     = a_valid_q & ~a_rej_q;
      a_to_d     = a_xfer & HREADY & ~cancel_q;
      rej_retire = a_valid_q & a_rej_q & ~d_valid_q;
      a_free     = ~a_valid_q | a_to_d | rej_retire;
      fifo_pop   = a_free & ~fifo_empty;
      d_done     = d_valid_q & HREADY;
   end

   // Next state for A, D, cancel and the response register.
   always_comb begin
      a_valid_d   = a_valid_q;
      a_rej_d     = a_rej_q;
      a_addr_d    = a_addr_q;
      a_write_d   = a_write_q;
      a_size_d    = a_size_q;
      a_wdata_d   = a_wdata_q;
      d_valid_d   = d_valid_q;
      d_write_d   = d_write_q;
      d_wdata_d   = d_wdata_q;
      cancel_d    = cancel_q;
      rsp_valid_d = 1'b0;
      rsp_write_d = 1'b0;
      rsp_error_d = 1'b0;
      rsp_rdata_d = '0;

      if (a_free) begin
         a_valid_d = ~fifo_empty;
         if (!fifo_empty) begin
            a_rej_d   = head_rej;
            a_addr_d  = head_addr;
            a_write_d = head_write;
            a_size_d  = head_size;
            a_wdata_d = head_wdata;
         end
      end

      if (d_done) d_valid_d = 1'b0;
      if (a_to_d) begin
         d_valid_d = 1'b1;
         d_write_d = a_write_q;
         d_wdata_d = a_wdata_q;
      end

      // ERROR first cycle (HREADY low) arms cancel; HREADY high releases it.
      if (cancel_q) cancel_d = ~HREADY;
      else          cancel_d = d_valid_q & ~HREADY & (HRESP == HRESP_ERROR);

      if (d_done) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = d_write_q;
         rsp_error_d = (HRESP == HRESP_ERROR);
         if (!d_write_q && (HRESP == HRESP_OKAY)) rsp_rdata_d = HRDATA;
      end else if (rej_retire) begin
         rsp_valid_d = 1'b1;
         rsp_write_d = a_write_q;
         rsp_error_d = 1'b1;
      end
   end

   // Pipeline state registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         a_valid_q   <= 1'b0;
         a_rej_q     <= 1'b0;
         a_addr_q    <= '0;
         a_write_q   <= 1'b0;
         a_size_q    <= 3'd0;
         a_wdata_q   <= '0;
         d_valid_q   <= 1'b0;
         d_write_q   <= 1'b0;
         d_wdata_q   <= '0;
         cancel_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_write_q <= 1'b0;
         rsp_error_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         a_valid_q   <= a_valid_d;
         a_rej_q     <= a_rej_d;
         a_addr_q    <= a_addr_d;
         a_write_q   <= a_write_d;
         a_size_q    <= a_size_d;
         a_wdata_q   <= a_wdata_d;
         d_valid_q   <= d_valid_d;
         d_write_q   <= d_write_d;
         d_wdata_q   <= d_wdata_d;
         cancel_q    <= cancel_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_write_q <= rsp_write_d;
         rsp_error_q <= rsp_error_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   // Bus and response outputs, all derived from registered state.
   always_comb begin
      htrans    = (a_xfer && !cancel_q) ? HTRANS_NONSEQ : HTRANS_IDLE;
      HTRANS    = htrans;
      HADDR     = a_addr_q;
      HWRITE    = a_write_q;
      HSIZE     = a_size_q;
      HBURST    = HBURST_SINGLE;
      HWDATA    = (d_valid_q && d_write_q) ? d_wdata_q : '0;
      rsp_valid = rsp_valid_q;
      rsp_write = rsp_write_q;
      rsp_error = rsp_error_q;
      rsp_rdata = rsp_rdata_q;
      busy      = ~fifo_empty | a_valid_q | d_valid_q;
   end

endmodule
